// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_mem_pkg
// Description : Shared types and defaults for the MAR/MDR memory interface.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_mem_pkg;

  // Access state of the memory bus unit
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } mem_state_e;

  localparam int unsigned CPU_ADDR_W = 9;
  localparam int unsigned CPU_DATA_W = 32;

  // Bit value replicated across MDR when a read is abandoned
  localparam logic MDR_TIMEOUT_FILL = 1'b0;

endpackage : cpu_mem_pkg
`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_timeout_ctr
// Description : Cycle counter for an outstanding RAM request. Clears at issue,
//               counts while enabled, flags expiry on the TIMEOUT-th cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Count value k-1 is held during the k-th request cycle, so expiry is seen
  // in cycle TIMEOUT and the request drops on the edge that ends it.
  assign expired = enable & (cnt_q == CW'(TIMEOUT - 1));

  // Next count: clear wins over counting; saturate once expired
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : mem_timeout_ctr
`default_nettype wire

// File: rtl/mem_bus_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_unit
// Description : MAR/MDR memory interface with req/ack RAM handshake, request
//               timeout with sticky error, and a one-deep pending read that
//               lets a write and a read start in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_unit
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W  = CPU_ADDR_W,
  parameter int DATA_W  = CPU_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [DATA_W-1:0] BusMuxOut,
  input  logic              MAR_enable,
  input  logic              MDR_enable,
  input  logic              MDR_read,
  input  logic              RAM_write,
  output logic [DATA_W-1:0] MDR_data,
  output logic              Mem_busy,
  output logic              Mem_err,
  output logic              Prot_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  mem_state_e        state_q,     state_d;
  logic              pending_q,   pending_d;
  logic              ram_wr_q,    ram_wr_d;
  logic [ADDR_W-1:0] mar_q,       mar_d;
  logic [DATA_W-1:0] mdr_q,       mdr_d;
  logic              mem_err_q,   mem_err_d;
  logic              prot_err_q,  prot_err_d;
  logic              mem_req_q,   mem_req_d;
  logic              mem_we_q,    mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic wr_rise;
  logic rd_start;
  logic issue;
  logic expired;

  assign wr_rise  = RAM_write & ~ram_wr_q;
  assign rd_start = MDR_enable & MDR_read;

  // Request timer: held clear while idle and re-cleared on every issue
  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (Clock),
    .rst_n   (Reset),
    .clear   (issue | ~mem_req_q),
    .enable  (mem_req_q),
    .expired (expired)
  );

  // Next-state logic: bus loads, access issue, completion and timeout
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    ram_wr_d    = RAM_write;
    mar_d       = mar_q;
    mdr_d       = mdr_q;
    mem_err_d   = mem_err_q;
    prot_err_d  = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    issue       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (MAR_enable) begin
          mar_d = BusMuxOut[ADDR_W-1:0];
        end
        if (MDR_enable && !MDR_read) begin
          mdr_d = BusMuxOut;
        end
        // Issue captures the current registers, not this cycle's loads
        if (wr_rise) begin
          state_d     = ST_WRITE;
          pending_d   = rd_start;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = mar_q;
          mem_wdata_d = mdr_q;
          issue       = 1'b1;
        end else if (rd_start) begin
          state_d    = ST_READ;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = mar_q;
          issue      = 1'b1;
        end
      end

      ST_READ, ST_WRITE: begin
        prot_err_d = MAR_enable | MDR_enable | wr_rise;
        if (mem_req_q && (mem_ack || expired)) begin
          // An ack on the expiry edge still counts as success
          if (state_q == ST_READ) begin
            mdr_d = mem_ack ? mem_rdata : {DATA_W{MDR_TIMEOUT_FILL}};
          end
          if (!mem_ack) begin
            mem_err_d = 1'b1;
          end
          if (pending_q) begin
            // MAR cannot change while busy, so it still holds the read address
            state_d    = ST_READ;
            pending_d  = 1'b0;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = mar_q;
            issue      = 1'b1;
          end else begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d   = ST_IDLE;
        pending_d = 1'b0;
        mem_req_d = 1'b0;
        mem_we_d  = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      pending_q   <= 1'b0;
      ram_wr_q    <= 1'b0;
      mar_q       <= '0;
      mdr_q       <= '0;
      mem_err_q   <= 1'b0;
      prot_err_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      ram_wr_q    <= ram_wr_d;
      mar_q       <= mar_d;
      mdr_q       <= mdr_d;
      mem_err_q   <= mem_err_d;
      prot_err_q  <= prot_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign MDR_data  = mdr_q;
  assign Mem_busy  = (state_q != ST_IDLE) | pending_q;
  assign Mem_err   = mem_err_q;
  assign Prot_err  = prot_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule : mem_bus_unit
`default_nettype wire
